// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FETCH_MISALIGN_FAULT_EN adds the FAULT state.
package fetch_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned PC_STEP = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [STATE_W-1:0] {
    FETCH,
    WAIT,
    HOLD,
    DROP
`ifdef FETCH_MISALIGN_FAULT_EN
    , FAULT
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// buffers the returned word and hands it to decode over valid/ready.
// Build option FETCH_MISALIGN_FAULT_EN: misaligned redirects raise a sticky
// fetch_fault and park the stage in FAULT; otherwise the low two bits of
// the redirect target are cleared.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_en,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic [ADDR_WIDTH-1:0]  instr_pc4,
  input  logic                   instr_ready
`ifdef FETCH_MISALIGN_FAULT_EN
  ,
  output logic                   fetch_fault
`endif
);

  fetch_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  pc_next;
  logic [ADDR_WIDTH-1:0]  redirect_tgt;
  logic                   instr_valid_d;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic [ADDR_WIDTH-1:0]  instr_pc_d, instr_pc4_d;
`ifdef FETCH_MISALIGN_FAULT_EN
  logic                   fetch_fault_d;
`endif

  // Sequential PC, word-aligned redirect target, request driven straight from state
  assign pc_next      = pc_q + ADDR_WIDTH'(PC_STEP);
  assign redirect_tgt = redirect_pc & ~ADDR_WIDTH'(3);
  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;

  // State, PC and decode-facing buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= INSTR_WIDTH'(INSTR_NOP);
      instr_pc    <= RESET_PC;
      instr_pc4   <= RESET_PC + ADDR_WIDTH'(PC_STEP);
`ifdef FETCH_MISALIGN_FAULT_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_valid <= instr_valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_pc4   <= instr_pc4_d;
`ifdef FETCH_MISALIGN_FAULT_EN
      fetch_fault <= fetch_fault_d;
`endif
    end
  end

  // Next state and next buffer contents; a redirect wins over every other event
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr;
    instr_pc_d  = instr_pc;
    instr_pc4_d = instr_pc4;
`ifdef FETCH_MISALIGN_FAULT_EN
    fetch_fault_d = fetch_fault;
`endif

    case (state_q)
      FETCH: begin
        if (redirect_en) begin
          pc_d    = redirect_tgt;
          state_d = imem_ready ? DROP : FETCH;
        end else if (imem_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_en) begin
          pc_d    = redirect_tgt;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          instr_d     = imem_rdata;
          instr_pc_d  = pc_q;
          instr_pc4_d = pc_next;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (redirect_en) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_next;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (redirect_en) begin
          pc_d = redirect_tgt;
        end else if (imem_rvalid) begin
          state_d = FETCH;
        end
      end
      default: state_d = state_q;
    endcase

`ifdef FETCH_MISALIGN_FAULT_EN
    // Misaligned target: park until reset, ignoring everything else
    if (state_q != FAULT && redirect_en && (redirect_pc[1:0] != 2'b00)) begin
      pc_d          = pc_q;
      state_d       = FAULT;
      fetch_fault_d = 1'b1;
    end
`endif

    instr_valid_d = (state_d == HOLD);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// every cycle against a flag-based transaction model and a simple memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_ready;
`ifdef FETCH_MISALIGN_FAULT_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_pc4   (instr_pc4),
    .instr_ready (instr_ready)
`ifdef FETCH_MISALIGN_FAULT_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what the stage is doing, as flags
  bit          m_wait, m_discard, m_hold, m_fault;
  logic [31:0] m_pc, m_instr, m_ipc;

  // Memory environment
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          min_lat = 0;
  int          max_lat = 0;
  bit          stale_pending;
  logic [31:0] acc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic bit m_fetching();
    return !(m_wait || m_discard || m_hold || m_fault);
  endfunction

  // One clock: drive at negedge time, update environment and model at posedge,
  // then compare outputs at the following negedge.
  task automatic cycle(input bit r, input bit redir, input logic [31:0] rpc,
                       input bit rdy, input bit irdy);
    bit          rv;
    logic [31:0] rd;
    bit          req_s;
    logic [31:0] addr_s;
    bit          fetching;
    rv = 1'b0;
    rd = $urandom;
    if (!r && mem_busy && mem_lat == 0) begin
      rv = 1'b1;
      rd = word(mem_addr);
    end else if (!r && stale_pending && !mem_busy) begin
      rv = 1'b1;
    end
    stale_pending = r;
    rst = r; redirect_en = redir; redirect_pc = rpc;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd; instr_ready = irdy;
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge clk);
    if (r) begin
      mem_busy = 1'b0;
    end else begin
      if (rv && mem_busy) mem_busy = 1'b0;
      else if (mem_busy) mem_lat--;
      if (req_s && rdy) begin
        mem_busy = 1'b1;
        mem_addr = addr_s;
        mem_lat  = $urandom_range(max_lat, min_lat);
        acc_q.push_back(addr_s);
      end
    end
    if (r) begin
      m_wait = 0; m_discard = 0; m_hold = 0; m_fault = 0;
      m_pc = 32'h0; m_instr = 32'h0000_0013; m_ipc = 32'h0;
    end else if (!m_fault) begin
      fetching = m_fetching();
      if (redir) begin
`ifdef FETCH_MISALIGN_FAULT_EN
        if (rpc[1:0] != 2'b00) begin
          m_fault = 1; m_wait = 0; m_discard = 0; m_hold = 0;
        end else
`endif
        begin
          if (fetching) m_discard = rdy;
          else if (m_wait) begin m_wait = 0; m_discard = !rv; end
          m_hold = 0;
          m_pc = {rpc[31:2], 2'b00};
        end
      end else if (fetching) begin
        if (rdy) m_wait = 1;
      end else if (m_wait) begin
        if (rv) begin m_wait = 0; m_hold = 1; m_instr = rd; m_ipc = m_pc; end
      end else if (m_hold) begin
        if (irdy) begin m_hold = 0; m_pc = m_pc + 32'd4; end
      end else if (m_discard && rv) begin
        m_discard = 0;
      end
    end
    @(negedge clk);
    check("imem_req", 32'(imem_req), 32'(m_fetching()));
    if (m_fetching()) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(m_hold));
    check("instr", instr, m_instr);
    check("instr_pc", instr_pc, m_ipc);
    check("instr_pc4", instr_pc4, m_ipc + 32'd4);
`ifdef FETCH_MISALIGN_FAULT_EN
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`endif
  endtask

  task automatic do_reset();
    cycle(1, 0, 32'h0, 0, 0);
    cycle(1, 0, 32'h0, 0, 0);
  endtask

  initial begin
    bit found;
    logic [31:0] rpc;
    rst = 1; redirect_en = 0; redirect_pc = 0; imem_ready = 0;
    imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;

    // Reset values
    do_reset();
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc4", instr_pc4, 32'h4);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Zero-wait streaming: addresses 0, 4, 8
    acc_q.delete();
    for (int i = 0; i < 9; i++) cycle(0, 0, 32'h0, 1, 1);
    check("acc_cnt", 32'(acc_q.size() >= 3), 32'h1);
    if (acc_q.size() >= 3) begin
      check("acc0", acc_q[0], 32'h0);
      check("acc1", acc_q[1], 32'h4);
      check("acc2", acc_q[2], 32'h8);
    end

    // Decode stall in HOLD
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, 0, 32'h0, 1, 0);
    check("stall_req", 32'(imem_req), 32'h0);
    check("stall_pc", instr_pc, 32'h0);
    cycle(0, 0, 32'h0, 1, 1);
    check("after_stall_addr", imem_addr, 32'h4);

    // Redirect coincident with response in WAIT
    do_reset();
    cycle(0, 0, 32'h0, 1, 1);
    cycle(0, 1, 32'h100, 1, 1);
    check("redir_rv_addr", imem_addr, 32'h100);
    check("redir_rv_valid", 32'(instr_valid), 32'h0);

    // Redirect in WAIT with late response
    min_lat = 3; max_lat = 3;
    do_reset();
    cycle(0, 0, 32'h0, 1, 1);
    cycle(0, 1, 32'h40, 1, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(0, 0, 32'h0, 1, 0);
      found = instr_valid;
    end
    check("late_found", 32'(found), 32'h1);
    check("late_pc", instr_pc, 32'h40);
    min_lat = 0; max_lat = 0;

    // Reset while in WAIT, stale response afterwards
    do_reset();
    cycle(0, 0, 32'h0, 1, 1);
    cycle(1, 0, 32'h0, 0, 0);
    cycle(0, 0, 32'h0, 0, 1);
    check("stale_valid", 32'(instr_valid), 32'h0);
    check("stale_instr", instr, 32'h0000_0013);
    check("stale_addr", imem_addr, 32'h0);

    // Misaligned redirect
    do_reset();
    cycle(0, 1, 32'h102, 0, 1);
`ifdef FETCH_MISALIGN_FAULT_EN
    check("mis_fault", 32'(fetch_fault), 32'h1);
    cycle(0, 1, 32'h200, 1, 1);
    check("mis_req", 32'(imem_req), 32'h0);
`else
    check("mis_addr", imem_addr, 32'h100);
`endif

    // Randomized traffic
    min_lat = 0; max_lat = 3;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rpc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, rpc,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode/control logic; owns the PC.
- Issues one request at a time to instruction memory and buffers the returned word.
- Presents instruction, PC and PC+4 to decode over a valid/ready handshake.
- Accepts redirects (branch taken / JAL target) computed downstream from PCSrc and J.

Parameters:
- ADDR_WIDTH, 32, PC and imem address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_en  in  1  branch taken or JAL (PCSrc | J from control).
- redirect_pc  in  ADDR_WIDTH  target address.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_WIDTH  request address.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  INSTR_WIDTH  response word.
- instr_valid  out  1  instruction held for decode.
- instr  out  INSTR_WIDTH  instruction to decode (op/funct3/funct7 source).
- instr_pc  out  ADDR_WIDTH  PC of instr.
- instr_pc4  out  ADDR_WIDTH  instr_pc + 4 (JAL link value).
- instr_ready  in  1  decode consumes instr.

Behaviour:
- Reset values: state=FETCH, pc=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_pc4=RESET_PC+4.
- imem_req and imem_addr are combinational from state: imem_req=1 only in FETCH; imem_addr=pc.
- At most one request outstanding.
- FSM states:
  - FETCH: on imem_req&imem_ready, go WAIT.
  - WAIT: on imem_rvalid, register imem_rdata into instr; instr_pc=pc; instr_pc4=pc+4 (mod 2^ADDR_WIDTH, wraps); go HOLD.
  - HOLD: instr_valid=1 (registered, so first visible the cycle after rvalid); on instr_ready, pc<=pc+4, go FETCH.
  - DROP: waiting to discard a stale response; on imem_rvalid discard it, go FETCH.
- Best-case throughput: one instruction per 3 cycles (FETCH, WAIT, HOLD) with zero-wait memory.
- Redirect has priority over every other event in every state; pc<=redirect_pc.
  - FETCH without handshake: stay FETCH; the new address appears next cycle.
  - FETCH with imem_req&imem_ready in the same cycle: go DROP.
  - WAIT: go DROP. If imem_rvalid arrives in the same cycle, discard it and go FETCH instead.
  - HOLD: clear instr_valid next cycle; go FETCH. A simultaneous instr_ready does not add 4.
  - DROP: stay DROP with updated pc.
- imem_rvalid in FETCH or HOLD is a protocol violation. Ignore it, except when state was forced to FETCH by rst; those responses are discarded silently.
- instr_valid must not drop without instr_ready or redirect. instr and instr_pc are stable while instr_valid=1.
- rst mid-operation: immediate return to reset values; any outstanding response is ignored. imem is reset by the same rst.
- Misaligned redirect_pc[1:0]!=0 is handled per the optional feature.

Optional Feature:
- Macro FETCH_MISALIGN_FAULT_EN.
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault sticky and enters state FAULT.
  - In FAULT: imem_req=0, instr_valid=0, later redirects ignored, until rst.
  - Any outstanding response is ignored.
- Undefined: redirect_pc[1:0] is forced to 2'b00 before loading pc; no fetch_fault port.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, HOLD, DROP, FAULT}; FAULT exists only under the macro.
  - INSTR_NOP = 32'h0000_0013.
  - PC_STEP = 4.
- No sub-module; FSM, PC register and output buffer are one flat module.

Test Plan:
- Reset then zero-wait memory with imem_ready=1, rvalid one cycle after accept, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid every 3rd cycle; instr_pc4 = instr_pc+4.
- instr_ready held 0 for 5 cycles in HOLD -> instr, instr_pc stable; no new imem_req; pc advances only after ready.
- Redirect to 0x100 in the same cycle as rvalid in WAIT -> response discarded, next imem_addr = 0x100, instr_valid stays 0.
- Redirect to 0x40 while in WAIT, rvalid 3 cycles later -> DROP discards word, then request to 0x40, delivered instr_pc = 0x40.
- rst asserted while in WAIT, stale rvalid the cycle after release -> ignored; first request to RESET_PC; all outputs at reset values.
- With FETCH_MISALIGN_FAULT_EN, redirect to 0x102 -> fetch_fault=1 next cycle, imem_req=0 thereafter. Without the macro -> next imem_addr = 0x100.
